des_subkey_gen: RTL and testbench

DES_SUBKEY_GEN -- requirements
Module: des_subkey_gen

---
 rtl/des_subkey_gen.sv | 189 ++++++++++++++++++
 tb/tb_des_subkey_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_subkey_gen.sv
// DES round-key scheduler: PC-1 on start, per-round C/D rotation, PC-2 output,
// one subkey per cycle with valid/ready handshake in encrypt or decrypt order.
module des_subkey_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic        busy,
    output logic [47:0] subkey_out,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        done
);

    // Tables hold FIPS (1-based) bit numbers; vector index = FIPS bit - 1.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } state_t;

    state_t      state_reg;
    logic [27:0] c_reg, d_reg;
    logic [27:0] c_next, d_next;
    logic [3:0]  round_reg, round_next;
    logic        dec_reg;
    logic        busy_reg, valid_reg, done_reg;
    logic [47:0] subkey_reg;

    logic [55:0] pc1_out;
    logic [55:0] cd_next;
    logic [47:0] pc2_next;
    logic        last_round;

    // Parity bits of the key and the eight C/D bits PC-2 drops carry no information.
    logic [7:0]  unused_parity;
    logic [7:0]  unused_cd;

    genvar gi;

    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            localparam int SRC = PC1_TAB[gi] - 1;
            assign pc1_out[gi] = key_in[SRC];
        end
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            localparam int SRC = PC2_TAB[gi] - 1;
            assign pc2_next[gi] = cd_next[SRC];
        end
        for (gi = 0; gi < 8; gi++) begin : g_parity
            assign unused_parity[gi] = key_in[8*gi+7];
        end
    endgenerate

    assign unused_cd = {cd_next[53], cd_next[42], cd_next[37], cd_next[34],
                        cd_next[24], cd_next[21], cd_next[17], cd_next[8]};

    // C occupies FIPS bits 1..28 of the concatenation, D bits 29..56.
    assign cd_next = {d_next, c_next};

    // Rounds 1, 2, 9 and 16 (0-based 0, 1, 8, 15) shift by one, others by two.
    function automatic logic single_shift(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
    endfunction

    // FIPS-left: new bit k = old bit k+1, i.e. a vector shift toward index 0.
    function automatic logic [27:0] rot_left(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // FIPS-right: new bit k = old bit k-1.
    function automatic logic [27:0] rot_right(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    assign last_round = dec_reg ? (round_reg == 4'd0) : (round_reg == 4'd15);

    // Next C/D/round: in IDLE this forms the first presented round, in EMIT the following one.
    always_comb begin
        c_next     = c_reg;
        d_next     = d_reg;
        round_next = round_reg;
        if (state_reg == IDLE) begin
            if (dec_reg) begin
                round_next = 4'd15;
            end else begin
                round_next = 4'd0;
                c_next     = rot_left(c_reg, 1'b1);
                d_next     = rot_left(d_reg, 1'b1);
            end
        end else if (dec_reg) begin
            round_next = round_reg - 4'd1;
            c_next     = rot_right(c_reg, single_shift(round_reg));
            d_next     = rot_right(d_reg, single_shift(round_reg));
        end else begin
            round_next = round_reg + 4'd1;
            c_next     = rot_left(c_reg, single_shift(round_reg + 4'd1));
            d_next     = rot_left(d_reg, single_shift(round_reg + 4'd1));
        end
    end

    // Control FSM with registered outputs; IDLE with busy set is the load-to-first-round cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            c_reg      <= '0;
            d_reg      <= '0;
            round_reg  <= '0;
            dec_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
            subkey_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (busy_reg) begin
                        state_reg  <= EMIT;
                        c_reg      <= c_next;
                        d_reg      <= d_next;
                        round_reg  <= round_next;
                        subkey_reg <= pc2_next;
                        valid_reg  <= 1'b1;
                    end else if (start) begin
                        c_reg    <= pc1_out[27:0];
                        d_reg    <= pc1_out[55:28];
                        dec_reg  <= decrypt;
                        busy_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    if (subkey_ready) begin
                        if (last_round) begin
                            state_reg  <= FIN;
                            valid_reg  <= 1'b0;
                            subkey_reg <= '0;
                            round_reg  <= '0;
                            done_reg   <= 1'b1;
                        end else begin
                            c_reg      <= c_next;
                            d_reg      <= d_next;
                            round_reg  <= round_next;
                            subkey_reg <= pc2_next;
                        end
                    end
                end
                FIN: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_reg;
    assign subkey_out   = subkey_reg;
    assign subkey_valid = valid_reg;
    assign round_idx    = round_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Scoreboard bench for des_subkey_gen: a cumulative-shift reference model fills
// an expectation queue at stimulus time; a negedge monitor checks each transfer.
module tb_des_subkey_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] key_in = '0;
    logic        busy;
    logic [47:0] subkey_out;
    logic        subkey_valid;
    logic        subkey_ready = 1'b1;
    logic [3:0]  round_idx;
    logic        done;

    always #5 clk = ~clk;

    des_subkey_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .busy         (busy),
        .subkey_out   (subkey_out),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .done         (done)
    );

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int xfers_since = 0;
    bit rand_ready = 1'b0;

    logic [47:0] exp_key_q [$];
    logic [3:0]  exp_idx_q [$];
    logic [47:0] got_q [$];
    logic [3:0]  got_idx_q [$];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // K_r straight from the FIPS definition: C_r/D_r are C0/D0 rotated left by the
    // cumulative shift, so each subkey bit traces back to one key bit.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
        logic [47:0] k;
        int t, p, j, src;
        t = 0;
        for (int i = 0; i < r; i++) t += SHIFTS[i];
        for (int i = 0; i < 48; i++) begin
            p = PC2[i];
            if (p <= 28) begin
                j = (p - 1 + t) % 28;
                src = PC1[j];
            end else begin
                j = (p - 29 + t) % 28;
                src = PC1[28 + j];
            end
            k[i] = key[src - 1];
        end
        return k;
    endfunction

    // Hex literals are written FIPS bit 1 first; the vector carries FIPS bit 1 at index 0.
    function automatic logic [63:0] fips64(input logic [63:0] h);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = h[63 - i];
        return v;
    endfunction

    function automatic logic [47:0] fips48(input logic [47:0] h);
        logic [47:0] v;
        for (int i = 0; i < 48; i++) v[i] = h[47 - i];
        return v;
    endfunction

    task automatic push_sched(input logic [63:0] key, input bit dec);
        int r;
        for (int n = 0; n < 16; n++) begin
            r = dec ? 16 - n : n + 1;
            exp_key_q.push_back(ref_subkey(key, r));
            exp_idx_q.push_back(4'(r - 1));
        end
    endtask

    // Ready driver: tied high or ~50% random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            subkey_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: checks transfers against the scoreboard, hold stability, idle zeros, done.
    logic [47:0] prev_key;
    logic [3:0]  prev_idx;
    bit          prev_hold = 1'b0;
    initial begin
        logic [47:0] ek;
        logic [3:0]  ei;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold)
                    chk({subkey_valid, round_idx, subkey_out} == {1'b1, prev_idx, prev_key},
                        "hold_stable", {subkey_valid, round_idx, subkey_out}, {1'b1, prev_idx, prev_key});
                if (subkey_valid && subkey_ready) begin
                    if (exp_key_q.size() == 0) begin
                        chk(1'b0, "unexpected_xfer", subkey_out, 0);
                    end else begin
                        ek = exp_key_q.pop_front();
                        ei = exp_idx_q.pop_front();
                        chk(subkey_out == ek, "subkey", subkey_out, ek);
                        chk(round_idx == ei, "round_idx", round_idx, ei);
                    end
                    got_q.push_back(subkey_out);
                    got_idx_q.push_back(round_idx);
                    xfers_since++;
                    $display("xfer round_idx=%0d subkey=%h", round_idx, subkey_out);
                end
                if (!subkey_valid)
                    chk(subkey_out == 48'h0, "subkey_zero_when_invalid", subkey_out, 0);
                if (done) begin
                    chk(xfers_since == 16 && !subkey_valid, "done_after_16", xfers_since, 16);
                    done_cnt++;
                    xfers_since = 0;
                end
                prev_hold = subkey_valid && !subkey_ready;
                prev_key  = subkey_out;
                prev_idx  = round_idx;
            end
        end
    end

    // Start a schedule; returns at the first negedge with valid high.
    task automatic issue(input logic [63:0] key, input bit dec, input bit hold);
        int n;
        bit seen;
        push_sched(key, dec);
        @(posedge clk);
        #1;
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(posedge clk);
            n++;
            #1;
            if (!hold) start = 1'b0;
            if (n == 1)
                chk(busy == 1'b1 && subkey_valid == 1'b0, "busy_after_start", {busy, subkey_valid}, 2'b10);
            @(negedge clk);
            seen = subkey_valid;
        end
        chk(seen && n == 2, "valid_latency", n, 2);
        if (!hold) begin
            key_in  = {$urandom, $urandom};
            decrypt = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        chk(seen, name, n, 200);
        @(posedge clk);
        #1;
        chk(busy == 1'b0, "busy_fall_after_fin", busy, 0);
    endtask

    // With ready high: valid must stay up exactly 16 cycles, then one done pulse.
    task automatic count_run();
        int len;
        len = 1;
        while (len < 40) begin
            @(negedge clk);
            if (!subkey_valid) break;
            len++;
        end
        chk(len == 16, "valid_run_len", len, 16);
        chk(done == 1'b1, "done_after_run", done, 1);
        @(posedge clk);
        #1;
        chk(busy == 1'b0, "busy_fall_after_fin", busy, 0);
        @(negedge clk);
        chk(done == 1'b0, "done_single_pulse", done, 0);
    endtask

    task automatic wait_round(input logic [3:0] idx);
        int n;
        n = 0;
        while (!(subkey_valid && round_idx == idx) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(subkey_valid && round_idx == idx, "reach_round", round_idx, idx);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] kat, ka, kb;
        logic [47:0] k1, k16, acc;
        bit          db;
        int          d0, n;
        bit          seen;

        kat = fips64(64'h133457799BBCDFF1);
        k1  = fips48(48'h1B02EFFC7072);
        k16 = fips48(48'hCB3D8B0E17F5);

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk({busy, subkey_valid, done, round_idx, subkey_out} == '0, "reset_state",
            {busy, subkey_valid, done, round_idx, subkey_out}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known-answer, encrypt order, ready high.
        rand_ready = 1'b0;
        got_q.delete(); got_idx_q.delete(); d0 = done_cnt;
        issue(kat, 1'b0, 1'b0);
        count_run();
        chk(got_q.size() == 16, "kat_enc_count", got_q.size(), 16);
        chk(got_q[0] == k1, "kat_enc_k1", got_q[0], k1);
        chk(got_q[15] == k16, "kat_enc_k16", got_q[15], k16);
        chk(done_cnt - d0 == 1, "kat_enc_done_once", done_cnt - d0, 1);

        // Known-answer, decrypt order.
        got_q.delete(); got_idx_q.delete(); d0 = done_cnt;
        issue(kat, 1'b1, 1'b0);
        count_run();
        chk(got_q[0] == k16 && got_idx_q[0] == 4'd15, "kat_dec_first", {got_idx_q[0], got_q[0]}, {4'd15, k16});
        chk(got_q[15] == k1 && got_idx_q[15] == 4'd0, "kat_dec_last", {got_idx_q[15], got_q[15]}, {4'd0, k1});
        chk(done_cnt - d0 == 1, "kat_dec_done_once", done_cnt - d0, 1);

        // Known-answer under random backpressure.
        rand_ready = 1'b1;
        got_q.delete(); got_idx_q.delete(); d0 = done_cnt;
        issue(kat, 1'b0, 1'b0);
        wait_done("bp_done");
        chk(got_q.size() == 16, "bp_count", got_q.size(), 16);
        chk(got_q[0] == k1, "bp_k1", got_q[0], k1);
        chk(got_q[15] == k16, "bp_k16", got_q[15], k16);
        chk(done_cnt - d0 == 1, "bp_done_once", done_cnt - d0, 1);

        // Random keys, random order, random backpressure.
        for (int t = 0; t < 5; t++) begin
            got_q.delete(); got_idx_q.delete(); d0 = done_cnt;
            issue({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
            wait_done("rand_done");
            chk(got_q.size() == 16, "rand_count", got_q.size(), 16);
            chk(done_cnt - d0 == 1, "rand_done_once", done_cnt - d0, 1);
        end

        // start re-pulsed with another key during round 5 is ignored.
        rand_ready = 1'b0;
        got_q.delete(); got_idx_q.delete(); d0 = done_cnt;
        issue({$urandom, $urandom}, 1'b0, 1'b0);
        wait_round(4'd4);
        #1;
        start = 1'b1; key_in = {$urandom, $urandom}; decrypt = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("restart_done");
        chk(got_q.size() == 16, "restart_count", got_q.size(), 16);
        chk(done_cnt - d0 == 1, "restart_done_once", done_cnt - d0, 1);

        // Reset during round 9 aborts without done; then an all-zero key.
        issue({$urandom, $urandom}, 1'b0, 1'b0);
        wait_round(4'd8);
        #2 rst_n = 1'b0;
        #1;
        chk({busy, subkey_valid, done, round_idx, subkey_out} == '0, "reset_async",
            {busy, subkey_valid, done, round_idx, subkey_out}, 0);
        exp_key_q.delete(); exp_idx_q.delete();
        xfers_since = 0; d0 = done_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk(done_cnt == d0 && busy == 1'b0, "no_done_after_abort", {done_cnt - d0, busy}, 0);
        got_q.delete(); got_idx_q.delete();
        issue(64'h0, 1'($urandom_range(0, 1)), 1'b0);
        wait_done("zero_done");
        acc = '0;
        foreach (got_q[i]) acc |= got_q[i];
        chk(got_q.size() == 16, "zero_count", got_q.size(), 16);
        chk(acc == 48'h0, "zero_key_all_zero", acc, 0);

        // start held high across FIN: one done, then a fresh schedule from IDLE.
        got_q.delete(); got_idx_q.delete(); d0 = done_cnt;
        ka = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        db = 1'($urandom_range(0, 1));
        issue(ka, 1'b0, 1'b1);
        key_in = kb; decrypt = db;
        push_sched(kb, db);
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        chk(seen, "hold_first_done", n, 100);
        n = 0; seen = 1'b0;
        while (!seen && n < 8) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 2) start = 1'b0;
            @(negedge clk);
            seen = subkey_valid;
        end
        start = 1'b0;
        chk(seen && n == 3, "hold_restart_latency", n, 3);
        wait_done("hold_second_done");
        chk(got_q.size() == 32, "hold_count", got_q.size(), 32);
        chk(done_cnt - d0 == 2, "hold_done_twice", done_cnt - d0, 2);

        chk(exp_key_q.size() == 0, "scoreboard_drained", exp_key_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
